load_store_unit: RTL

- Initiator side of the data-memory port: accepts load/store requests from the CPU pipeline and drives the byte-addressed, big-endian, 32-bit data memory.
- The memory has a synchronous write on clk when WriteEnable is high, and a combinational read of the word at address..address+3.
- Adds byte/halfword/word sizing, sign/zero extension, read-modify-write for sub-word stores, and alignment/range checking.
- Sits between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_if.sv | 46 ++++
 rtl/lsu_lane_align.sv | 66 ++++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit.
//   size_e      : access size encoding as presented on req_size
//   state_e     : control FSM states of load_store_unit
//   MEM_BYTES_DEFAULT : default data-memory size in bytes
//   lane_mask() : which byte lanes of the big-endian 32-bit word an access
//                 touches (bit 3 = bits [31:24], bit 0 = bits [7:0])
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int MEM_BYTES_DEFAULT = 1024;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Big-endian: offset 0 is the most significant byte of the word.
    function automatic logic [3:0] lane_mask(size_e size, logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b1000 >> off;
            SZ_HALF: mask = off[1] ? 4'b0011 : 4'b1100;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Bundles the CPU request/response handshake and the data-memory bus of the
// load/store unit.
//   slave  : seen by load_store_unit (takes requests, drives the memory)
//   master : seen by the pipeline / memory side environment
// Request : req_valid, req_ready, req_write, req_size, req_signed,
//           req_addr, req_wdata
// Response: resp_valid, resp_ready, resp_rdata, resp_err
// Memory  : mem_addr, mem_wdata, mem_we, mem_rdata
// ---------------------------------------------------------------------------
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for a big-endian 32-bit memory.
//   size, is_signed, off : captured access attributes (off = addr[1:0])
//   old_word             : word currently read from memory
//   wdata                : right-justified store data
//   load_data            : selected lane, sign/zero extended to 32 bits
//   merged_word          : old_word with the store lane replaced by wdata
// ---------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic        is_signed,
    input  logic [1:0]  off,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [3:0]  mask;
    logic [31:0] ins_word;
    logic [31:0] shifted;

    assign mask = lane_mask(size, off);

    // Replicate the store data across the word so every candidate lane
    // already holds it; the mask then picks the one that is written.
    always_comb begin
        case (size)
            SZ_BYTE: ins_word = {4{wdata[7:0]}};
            SZ_HALF: ins_word = {2{wdata[15:0]}};
            default: ins_word = wdata;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = mask[gi] ? ins_word[gi*8 +: 8]
                                                     : old_word[gi*8 +: 8];
        end
    endgenerate

    // Shift the addressed lane down to bit 0: byte at offset k sits
    // (3-k)*8 bits up, half at offset 0 sits 16 bits up.
    always_comb begin
        shifted   = old_word;
        load_data = old_word;
        case (size)
            SZ_BYTE: begin
                shifted   = old_word >> {~off, 3'b000};
                load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                shifted   = old_word >> {~off[1], 4'b0000};
                load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                shifted   = old_word;
                load_data = old_word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator side of a byte-addressed, big-endian, 32-bit data memory with
// synchronous write and combinational read. Adds byte/half/word sizing,
// sign/zero extension, read-modify-write for sub-word stores and
// alignment / range checking.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : lsu_if.slave -- request/response handshake and memory bus
// Parameter MEM_BYTES: valid byte addresses are 0..MEM_BYTES-1.
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_e      state_q,      state_d;
    size_e       size_q,       size_d;
    logic        signed_q,     signed_d;
    logic [1:0]  off_q,        off_d;
    logic [31:0] wdata_q,      wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q,   resp_err_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;

    size_e       req_size_e;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_size_e = size_e'(bus.req_size);

    // Reject illegal size, misalignment, or an address past the memory.
    always_comb begin
        req_err = 1'b0;
        if (req_size_e == SZ_ILL)                             req_err = 1'b1;
        if (req_size_e == SZ_HALF && bus.req_addr[0])         req_err = 1'b1;
        if (req_size_e == SZ_WORD && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
        if ({1'b0, bus.req_addr} >= MEM_LIMIT)                req_err = 1'b1;
    end

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .is_signed   (signed_q),
        .off         (off_q),
        .old_word    (bus.mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    size_d       = req_size_e;
                    signed_d     = bus.req_signed;
                    off_d        = bus.req_addr[1:0];
                    wdata_d      = bus.req_wdata;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = req_err;
                    if (req_err) begin
                        // The memory bus is left untouched for rejected requests.
                        state_d = ST_RESP;
                    end else begin
                        mem_addr_d = {bus.req_addr[31:2], 2'b00};
                        if (!bus.req_write) begin
                            state_d = ST_LOAD;
                        end else if (req_size_e == SZ_WORD) begin
                            mem_wdata_d = bus.req_wdata;
                            state_d     = ST_WRITE;
                        end else begin
                            state_d = ST_RMW_RD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                resp_rdata_d = load_data;
                state_d      = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_wdata_d = merged_word;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Handshake strobes and write enable decode from state alone, so an
    // asynchronous reset drops mem_we immediately.
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.mem_we     = (state_q == ST_WRITE);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
